// File: rtl/skinny_mask_pkg.sv
// Shared constants and helpers for the three-share SKINNY masked datapath.
// Q294 stage used here: y = { b ^ a&d, a ^ c&d, c, d } with x = {d,c,b,a}.
package skinny_mask_pkg;

  localparam int NUM_CF        = 18;
  localparam int SHARES        = 3;
  localparam int RAND_PER_SBOX = 8;

  // Component-function layout: 9 terms per nonlinear output bit, 3 per share.
  localparam int CF_PER_SHARE  = 3;
  localparam int CF_BIT2_BASE  = 0;
  localparam int CF_BIT3_BASE  = 9;

  // One component-function cell: linear share term plus one cross product.
  function automatic logic nf_cf_1(input logic lin, input logic p, input logic q);
    return lin ^ (p & q);
  endfunction

  // Unmasked golden model of one quadratic stage.
  function automatic logic [3:0] q294_ref(input logic [3:0] x);
    return {x[1] ^ (x[0] & x[3]), x[0] ^ (x[2] & x[3]), x[2], x[3]};
  endfunction

endpackage

// File: rtl/q294_cf_slice.sv
// The 18 component functions of one masked nibble (combinational).
// Term (j,i) of an output bit pairs share j of one operand with share
// (j+i) mod 3 of the other, so the 9 terms of a bit cover the full product;
// the linear share term rides on the i=0 cell of each share domain.
module q294_cf_slice
  import skinny_mask_pkg::*;
(
  input  logic [SHARES-1:0] a,
  input  logic [SHARES-1:0] b,
  input  logic [SHARES-1:0] c,
  input  logic [SHARES-1:0] d,
  output logic [NUM_CF-1:0] cf
);

  for (genvar j = 0; j < SHARES; j++) begin : g_share
    for (genvar i = 0; i < CF_PER_SHARE; i++) begin : g_term
      localparam int K = (j + i) % SHARES;
      if (i == 0) begin : g_lin
        assign cf[CF_BIT2_BASE + CF_PER_SHARE*j + i] = nf_cf_1(a[j], c[j], d[K]);
        assign cf[CF_BIT3_BASE + CF_PER_SHARE*j + i] = nf_cf_1(b[j], a[j], d[K]);
      end else begin : g_cross
        assign cf[CF_BIT2_BASE + CF_PER_SHARE*j + i] = nf_cf_1(1'b0, c[j], d[K]);
        assign cf[CF_BIT3_BASE + CF_PER_SHARE*j + i] = nf_cf_1(1'b0, a[j], d[K]);
      end
    end
  end

endmodule

// File: rtl/skinny_sbox_layer_2o.sv
// Two-stage, stallable, second-order masked 4-bit S-box layer (3 shares).
// Stage 1 registers component functions, remasked linear bits and the
// compression masks; stage 2 compresses and remasks into the output register.
// Optional build macro SHARED_RAND_EN: one 8-bit r broadcast to all nibbles.
module skinny_sbox_layer_2o
  import skinny_mask_pkg::*;
#(
  parameter int NUM_SBOX = 16,
`ifdef SHARED_RAND_EN
  localparam int RW = RAND_PER_SBOX
`else
  localparam int RW = RAND_PER_SBOX * NUM_SBOX
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*NUM_SBOX-1:0] in1,
  input  logic [4*NUM_SBOX-1:0] in2,
  input  logic [4*NUM_SBOX-1:0] in3,
  input  logic [RW-1:0]         r,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*NUM_SBOX-1:0] out1,
  output logic [4*NUM_SBOX-1:0] out2,
  output logic [4*NUM_SBOX-1:0] out3
);

  logic s1_valid_r;
  logic out_valid_r;
  logic s1_adv_s;
  logic in_ready_s;
  logic s1_load_s;
  logic out_load_s;

  // Stage 1 may hand over when the output register is empty or draining.
  assign s1_adv_s   = ~out_valid_r | out_ready;
  assign in_ready_s = ~s1_valid_r | s1_adv_s;
  assign s1_load_s  = in_valid & in_ready_s;
  assign out_load_s = s1_adv_s & s1_valid_r;

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;

  // Valid flags of both stages; each holds while its stage is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      if (in_ready_s) begin
        s1_valid_r <= in_valid;
      end
      if (s1_adv_s) begin
        out_valid_r <= s1_valid_r;
      end
    end
  end

  for (genvar k = 0; k < NUM_SBOX; k++) begin : g_sbox
    logic [RAND_PER_SBOX-1:0] rn_s;
    logic [SHARES-1:0]        a_s, b_s, c_s, d_s;
    logic [NUM_CF-1:0]        cf_s;
    logic [NUM_CF-1:0]        cf_r;
    logic [1:0]               lin1_r, lin2_r, lin3_r;
    logic [3:0]               m_r;
    logic [3:0]               o1_d, o2_d, o3_d;
    logic [3:0]               o1_r, o2_r, o3_r;

`ifdef SHARED_RAND_EN
    assign rn_s = r;
`else
    assign rn_s = r[RAND_PER_SBOX*k +: RAND_PER_SBOX];
`endif

    // Each share bit as a {share3, share2, share1} vector.
    assign a_s = {in3[4*k+0], in2[4*k+0], in1[4*k+0]};
    assign b_s = {in3[4*k+1], in2[4*k+1], in1[4*k+1]};
    assign c_s = {in3[4*k+2], in2[4*k+2], in1[4*k+2]};
    assign d_s = {in3[4*k+3], in2[4*k+3], in1[4*k+3]};

    q294_cf_slice u_cf (
      .a  (a_s),
      .b  (b_s),
      .c  (c_s),
      .d  (d_s),
      .cf (cf_s)
    );

    // Compression: XOR of a share domain's three terms plus a zero-sum mask.
    assign o1_d = {(^cf_r[CF_BIT3_BASE +: CF_PER_SHARE]) ^ m_r[2],
                   (^cf_r[CF_BIT2_BASE +: CF_PER_SHARE]) ^ m_r[0],
                   lin1_r};
    assign o2_d = {(^cf_r[CF_BIT3_BASE + CF_PER_SHARE +: CF_PER_SHARE]) ^ m_r[3],
                   (^cf_r[CF_BIT2_BASE + CF_PER_SHARE +: CF_PER_SHARE]) ^ m_r[1],
                   lin2_r};
    assign o3_d = {(^cf_r[CF_BIT3_BASE + 2*CF_PER_SHARE +: CF_PER_SHARE]) ^ m_r[2] ^ m_r[3],
                   (^cf_r[CF_BIT2_BASE + 2*CF_PER_SHARE +: CF_PER_SHARE]) ^ m_r[0] ^ m_r[1],
                   lin3_r};

    // Stage-1 capture of component functions, remasked linear bits and masks.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cf_r   <= '0;
        lin1_r <= 2'b00;
        lin2_r <= 2'b00;
        lin3_r <= 2'b00;
        m_r    <= 4'h0;
      end else if (s1_load_s) begin
        cf_r   <= cf_s;
        lin1_r <= {in1[4*k+2] ^ rn_s[6], in1[4*k+3] ^ rn_s[4]};
        lin2_r <= {in2[4*k+2] ^ rn_s[7], in2[4*k+3] ^ rn_s[5]};
        lin3_r <= {in3[4*k+2] ^ rn_s[6] ^ rn_s[7], in3[4*k+3] ^ rn_s[4] ^ rn_s[5]};
        m_r    <= rn_s[3:0];
      end
    end

    // Output share register, loaded only when stage 1 hands over a slice.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        o1_r <= 4'h0;
        o2_r <= 4'h0;
        o3_r <= 4'h0;
      end else if (out_load_s) begin
        o1_r <= o1_d;
        o2_r <= o2_d;
        o3_r <= o3_d;
      end
    end

    assign out1[4*k +: 4] = o1_r;
    assign out2[4*k +: 4] = o2_r;
    assign out3[4*k +: 4] = o3_r;
  end

endmodule
